// File: rtl/fifo_stream_pkg.sv
// Shared constants and width helpers for the FIFO stream reader.
// The FIFO_STREAM_READER_STATS_EN build adds the statistics counters.
package fifo_stream_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_BUF_DEPTH = 2;

  localparam int STAT_WORDS_W = 32;
  localparam int STAT_EMPTY_W = 16;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_stream_landing_buf.sv
// Circular landing buffer for words returned by the FIFO.
// Any depth is supported; pointers wrap explicitly at BUF_DEPTH-1.
module fifo_stream_landing_buf
  import fifo_stream_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BUF_DEPTH = DEF_BUF_DEPTH,
  localparam int PW = ptr_w(BUF_DEPTH),
  localparam int CW = cnt_w(BUF_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [CW-1:0]     count
);

  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++)
        mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop)
        rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Speculative reader turning the shift FIFO read port into a valid/ready stream.
// Define FIFO_STREAM_READER_STATS_EN to add stat_words and stat_empty_reads.
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BUF_DEPTH = DEF_BUF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  output logic              fifo_read,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_val,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              proto_err
`ifdef FIFO_STREAM_READER_STATS_EN
  ,
  output logic [STAT_WORDS_W-1:0] stat_words,
  output logic [STAT_EMPTY_W-1:0] stat_empty_reads
`endif
);

  localparam int CW = cnt_w(BUF_DEPTH);
  localparam int OW = CW + 1;

  logic          pending;
  logic          discard;
  logic          pop;
  logic          push;
  logic          stray;
  logic [CW-1:0] count;
  logic [OW-1:0] occ;

  assign pop   = m_valid & m_ready;
  assign push  = pending & fifo_val & ~flush;
  assign stray = fifo_val & ~pending & ~discard & ~flush;

  // Slots already promised: held words, minus this pop, plus the word in flight.
  assign occ = {1'b0, count} - OW'(pop) + OW'(pending);

  assign fifo_read = en & ~flush & ~rst
                   & (occ < OW'(BUF_DEPTH));

  assign m_valid = (count != '0);

  fifo_stream_landing_buf #(
    .DATA_W    (DATA_W),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (fifo_data),
    .pop       (pop),
    .head      (m_data),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= 1'b0;
      discard   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      pending <= flush ? 1'b0 : fifo_read;
      discard <= flush;
      if (stray)
        proto_err <= 1'b1;
    end
  end

`ifdef FIFO_STREAM_READER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_words       <= '0;
      stat_empty_reads <= '0;
    end else begin
      if (pop)
        stat_words <= stat_words + 1'b1;
      if (pending & ~fifo_val & (stat_empty_reads != '1))
        stat_empty_reads <= stat_empty_reads + 1'b1;
    end
  end
`endif

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Consumer-side front end for the team's shift FIFO. It drives the FIFO `read` strobe and captures `out`/`val`.
- The FIFO returns data one cycle after an accepted read and exposes no empty flag. This block speculatively issues reads and buffers the returned words in a small circular buffer.
- It presents a standard valid/ready stream to downstream logic.
- It sits between the FIFO read port and any back-pressuring consumer.

Parameters:
- DATA_W, 8, width of each FIFO word and stream word.
- BUF_DEPTH, 2, number of entries in the internal landing buffer. Minimum is 1. A value of 2 or more is needed for one word per cycle.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  permits issuing new FIFO reads. Buffered words still drain when low.
- flush  input  1  single-cycle request to discard all buffered and in-flight words.
- fifo_read  output  1  read strobe to the FIFO.
- fifo_data  input  DATA_W  FIFO `out`.
- fifo_val  input  1  FIFO `val`; qualifies fifo_data one cycle after an accepted read.
- m_data  output  DATA_W  stream data, equal to the buffer head.
- m_valid  output  1  stream valid.
- m_ready  input  1  stream ready from the consumer.
- proto_err  output  1  sticky flag: fifo_val arrived with no read outstanding.

Behaviour:
- Reset values: fifo_read=0, m_valid=0, m_data=0, proto_err=0, count=0, pending=0, wr_ptr=rd_ptr=0. All state clears at the clk edge where rst=1, regardless of any operation in progress.
- State:
  - count, 0..BUF_DEPTH, width $clog2(BUF_DEPTH+1).
  - wr_ptr and rd_ptr, wrapping at BUF_DEPTH-1 back to 0. BUF_DEPTH need not be a power of two.
  - pending, 1 bit: a read was issued last cycle.
- pop = m_valid & m_ready.
- fifo_read (combinational) = en & ~flush & ~rst & ((count - pop + pending) < BUF_DEPTH). A read is never issued unless a landing slot is guaranteed.
- pending <= fifo_read every cycle; cleared by rst and by flush.
- Capture: if pending & fifo_val, write fifo_data into buf[wr_ptr], advance wr_ptr, and increment count.
- pending & ~fifo_val means the FIFO was empty. Nothing is captured; pending simply clears.
- ~pending & fifo_val sets proto_err; the data is dropped. proto_err clears only on rst.
- A push and a pop in the same cycle leave count unchanged and move both pointers. The count update is count + push - pop.
- m_valid = (count != 0). m_data = buf[rd_ptr]; it equals 0 when count=0 after reset.
- Once m_valid rises, m_data and m_valid hold until pop.
- Latency: read issued in cycle T, fifo_val in T+1, m_valid visible in T+2.
- Throughput: 1 word/cycle sustained when BUF_DEPTH>=2, the FIFO is non-empty, and m_ready=1.
- Flush: at the edge, count, pointers and pending are zeroed. A fifo_val arriving the cycle after flush belongs to a read already suppressed or discarded. It is ignored and does not set proto_err; a one-cycle discard flag covers this case. m_valid is 0 the cycle after flush.
- rst and flush together: rst wins, with the same result.
- en low: no new reads; an outstanding pending word is still captured.
- Buffer full (count=BUF_DEPTH, no pop): fifo_read=0.
- Ordering: words leave in exactly the order returned by the FIFO; no duplication.

Optional Feature:
- Macro: FIFO_STREAM_READER_STATS_EN.
- Defined: adds output port `stat_words`, 32 bits. It counts pops, wraps modulo 2^32, and clears on rst but not on flush. It also adds output port `stat_empty_reads`, 16 bits, which counts pending & ~fifo_val cycles and saturates at 16'hFFFF.
- Undefined: neither port nor their counters exist; all other behaviour is identical.

Decomposition:
- Package fifo_stream_pkg holds:
  - the default DATA_W and BUF_DEPTH constants;
  - localparam functions for pointer and count widths;
  - the stats counter widths (32, 16).
- Sub-module fifo_stream_landing_buf: the circular buffer with push/pop/flush inputs and head/count outputs.
- The top level holds read-issue logic, pending/discard tracking, proto_err, and optional stats.

Test Plan:
- FIFO pre-filled with A1,A2,A3, en=1, m_ready=1 → fifo_read high from cycle 0; m_valid from cycle 2; outputs A1,A2,A3 on consecutive cycles; 3 pops; proto_err=0.
- m_ready=0 with FIFO holding 5 words, BUF_DEPTH=2 → exactly 2 reads accepted, then fifo_read=0; m_data=first word held stable. Releasing m_ready → remaining 3 words delivered in order.
- Empty FIFO, en=1 → fifo_read pulses, fifo_val stays 0, m_valid stays 0. With stats on, stat_empty_reads increments each read cycle.
- Flush asserted in the cycle a read is issued, with 1 word buffered → next cycle m_valid=0; the returning fifo_val is ignored; proto_err=0; the next word is delivered normally afterwards.
- Inject fifo_val=1 with no read outstanding → proto_err=1 and stays set; buffer count unchanged; rst clears it to 0.
- rst asserted mid-stream with 2 words buffered and a read pending → the following cycle m_valid=0, fifo_read=0, count=0, and the stats counters are 0.
